// File: rtl/xor_deser_pkg.sv
// Shared types and constants for the XOR-stage bit deserializer.
// Width default, counter sizing and out-register state encoding.
package xor_deser_pkg;

  localparam int DESER_WIDTH_DEF = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } oreg_st_e;

endpackage

// File: rtl/xor_deser_outreg.sv
// One-entry word holding register: load, drain and stall decode.
// Parity bit is carried only when DESER_PARITY_EN is defined.
module xor_deser_outreg
  import xor_deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef DESER_PARITY_EN
  input  logic             par_i,
  output logic             par_o,
`endif
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  oreg_st_e         st_q, st_d;
  logic [WIDTH-1:0] data_q, data_d;
`ifdef DESER_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= EMPTY;
      data_q <= '0;
`ifdef DESER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
`ifdef DESER_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  // A load while FULL only happens when the old word drains this cycle.
  always_comb begin
    st_d   = st_q;
    data_d = data_q;
`ifdef DESER_PARITY_EN
    par_d  = par_q;
`endif
    unique case (st_q)
      EMPTY: begin
        if (load_i) st_d = FULL;
      end
      FULL: begin
        if (load_i)       st_d = FULL;
        else if (ready_i) st_d = EMPTY;
      end
      default: st_d = EMPTY;
    endcase
    if (load_i) begin
      data_d = data_i;
`ifdef DESER_PARITY_EN
      par_d  = par_i;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = (st_q == FULL);
`ifdef DESER_PARITY_EN
  assign par_o   = par_q;
`endif

endmodule

// File: rtl/xor_bit_deser.sv
// Serial-to-parallel deserializer for the XOR bit stage, LSB first.
// Optional even-parity output word_par with DESER_PARITY_EN.
module xor_bit_deser
  import xor_deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             sync,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready
`ifdef DESER_PARITY_EN
  ,
  output logic             word_par
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // The top bit of a word is never stored: it arrives as bit_in.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last, acc, load;
  logic [WIDTH-1:0] word_nxt;

  assign last      = (cnt_q == CNT_LAST);
  assign bit_ready = !(last && word_valid && !word_ready);
  assign acc       = bit_valid && bit_ready;
  assign word_nxt  = {bit_in, sr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    load  = 1'b0;
    if (sync) begin
      cnt_d = acc ? CW'(1) : '0;
      if (acc) sr_d[0] = bit_in;
    end else if (acc) begin
      if (last) begin
        cnt_d = '0;
        load  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (cnt_q == CW'(i)) sr_d[i] = bit_in;
        end
      end
    end
  end

  xor_deser_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .data_i  (word_nxt),
`ifdef DESER_PARITY_EN
    .par_i   (^word_nxt),
    .par_o   (word_par),
`endif
    .ready_i (word_ready),
    .data_o  (word_out),
    .valid_o (word_valid)
  );

endmodule
